fetch_buffer: RTL and testbench
===============================

FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter: DEPTH, 8, number of instruction entries; a power of two, at least 4.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 flush  input  1  discard all buffered instructions (branch redirect or exception).
REQ-005 in_valid  input  1  fetch stage presents instructions this cycle.
REQ-006 in_two  input  1  0: one instruction (in_inst0 only); 1: two instructions.
REQ-007 in_pc  input  32  PC of in_inst0; PC of in_inst1 is in_pc+4.
REQ-008 in_inst0, in_inst1  input  32 each  instruction words (icache low/high words).
REQ-009 in_ready  output  1  buffer accepts a push this cycle.
REQ-010 out0_valid, out1_valid  output  1 each  oldest / second-oldest entry valid.
REQ-011 out0_pc, out0_inst, out1_pc, out1_inst  output  32 each  oldest two entries.
REQ-012 out_pop  input  2  decoder consumes 0, 1 or 2 entries this cycle.

Function
REQ-013 Storage: circular FIFO of DEPTH entries, each {pc[31:0], inst[31:0]}; head/tail pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
REQ-014 in_ready = (DEPTH - count) >= 2 from the registered count only; same-cycle pops do not raise it; no combinational path from out_pop or in_valid to in_ready.
REQ-015 Push fires when in_valid & in_ready & !flush; writes in_inst0/in_pc at tail, and when in_two=1 also in_inst1/in_pc+4 at tail+1; tail advances 1+in_two.
REQ-016 in_valid while !in_ready: no write, no state change; upstream holds its data.
REQ-017 out0_valid = count>=1; out1_valid = count>=2; out0 reads head, out1 reads head+1 (mod DEPTH); data on invalid outputs is don't-care.
REQ-018 Pop: head advances by out_pop when !flush; out_pop=1 with count=0, or out_pop=2 with count<2, is a protocol violation; the bench asserts against it and design behaviour is undefined.
REQ-019 Simultaneous push and pop: count_next = count + pushed - popped in one cycle; a push into a FIFO that is full after the pop is impossible because of REQ-014.
REQ-020 flush has priority: count, head, tail become 0 next cycle; the same-cycle push and pop are ignored; out*_valid are 0 the cycle after flush.
REQ-021 Latency (macro off): an instruction pushed in cycle N is first visible on out0/out1 in cycle N+1.
REQ-022 Program order: the out0 output always holds the oldest buffered instruction; the PC sequence is preserved across wrap-around.

Reset
REQ-023 While resetn=0 at a clock edge: count, head and tail become 0; out0_valid, out1_valid become 0; in_ready reads 1 after reset; entry contents are not reset.
REQ-024 Reset overrides flush, push and pop in the same cycle.

Configuration
REQ-025 Macro FETCH_BUF_BYPASS_EN: when defined and count=0 and a push fires, in_inst0/in_pc (and in_inst1/in_pc+4 if in_two) drive out0/out1 combinationally in the same cycle with out*_valid set. out_pop consumes them directly, and only unconsumed instructions are written to the FIFO (count_next = pushed - popped). In this mode in_ready must not depend on out_pop.
REQ-026 Without FETCH_BUF_BYPASS_EN: no combinational path from in_* to out*; REQ-021 latency applies.

Verification
REQ-027 Reset, then push in_pc=0x1c000000, in_two=1, no pop -> next cycle out0_pc=0x1c000000, out1_pc=0x1c000004, both valid, count=2.
REQ-028 Push pairs each cycle with out_pop=0 from empty (DEPTH=8) -> in_ready drops to 0 when count=7 or 8. Further in_valid is ignored and contents are unchanged.
REQ-029 count=7, push in_two=1 with out_pop=2 -> push rejected (in_ready=0). Next cycle count=5, and in_ready=1.
REQ-030 Sustained push of 2 and pop of 2 for 20 cycles starting at PC 0x1c000000 -> out0_pc increments by 8 each cycle across pointer wrap, with no loss and no duplication.
REQ-031 count=5, flush with in_valid=1 and out_pop=1 in the same cycle -> next cycle count=0, out0_valid=0, and the pushed data is never output.
REQ-032 FETCH_BUF_BYPASS_EN defined: empty buffer, push in_two=1 with out_pop=1 in the same cycle -> out0_pc=in_pc the same cycle; next cycle count=1 and out0_pc=in_pc+4.

Source files
------------

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buffer
// Description : Dual-issue instruction fetch FIFO (DEPTH entries of {pc,inst}).
//               Optional same-cycle bypass when empty: define FETCH_BUF_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        in_valid,
    input  logic        in_two,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst0,
    input  logic [31:0] in_inst1,
    output logic        in_ready,
    output logic        out0_valid,
    output logic        out1_valid,
    output logic [31:0] out0_pc,
    output logic [31:0] out0_inst,
    output logic [31:0] out1_pc,
    output logic [31:0] out1_inst,
    input  logic [1:0]  out_pop
);

    localparam int              c_PTR_W = $clog2(DEPTH);
    localparam int              c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    logic [31:0]        r_pc   [DEPTH];
    logic [31:0]        r_inst [DEPTH];
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;

    logic [c_CNT_W-1:0] w_free;
    logic               w_push;
    logic [1:0]         w_npush;
    logic               w_bypass;
    logic [1:0]         w_skip;
    logic [c_PTR_W-1:0] w_head1;
    logic [c_PTR_W-1:0] w_wr1;

    // Readiness looks only at the registered count so it never sees out_pop.
    assign w_free   = c_DEPTH - r_count;
    assign in_ready = (w_free >= c_CNT_W'(2));
    assign w_push   = in_valid & in_ready & ~flush;
    assign w_npush  = w_push ? (in_two ? 2'd2 : 2'd1) : 2'd0;

`ifdef FETCH_BUF_BYPASS_EN
    assign w_bypass = w_push & (r_count == '0);
`else
    assign w_bypass = 1'b0;
`endif

    // Entries consumed straight from the inputs are never written.
    assign w_skip  = w_bypass ? out_pop : 2'd0;
    assign w_head1 = r_head + 1'b1;
    assign w_wr1   = (w_skip == 2'd0) ? (r_tail + 1'b1) : r_tail;

    always_comb begin
        out0_valid = (r_count != '0) | w_bypass;
        out1_valid = (r_count >= c_CNT_W'(2)) | (w_bypass & in_two);
        out0_pc    = r_pc[r_head];
        out0_inst  = r_inst[r_head];
        out1_pc    = r_pc[w_head1];
        out1_inst  = r_inst[w_head1];
        if (w_bypass) begin
            out0_pc   = in_pc;
            out0_inst = in_inst0;
            out1_pc   = in_pc + 32'd4;
            out1_inst = in_inst1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
        end else if (flush) begin
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_count <= r_count + c_CNT_W'(w_npush) - c_CNT_W'(out_pop);
            r_head  <= r_head + c_PTR_W'(out_pop - w_skip);
            r_tail  <= r_tail + c_PTR_W'(w_npush - w_skip);
        end
    end

    // Storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (resetn && w_push) begin
            if (w_skip == 2'd0) begin
                r_pc[r_tail]   <= in_pc;
                r_inst[r_tail] <= in_inst0;
            end
            if (in_two && (w_skip != 2'd2)) begin
                r_pc[w_wr1]    <= in_pc + 32'd4;
                r_inst[w_wr1]  <= in_inst1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_buffer
// Description : Scoreboard bench for fetch_buffer (DEPTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic        in_two;
    logic [31:0] in_pc;
    logic [31:0] in_inst0;
    logic [31:0] in_inst1;
    logic        in_ready;
    logic        out0_valid;
    logic        out1_valid;
    logic [31:0] out0_pc;
    logic [31:0] out0_inst;
    logic [31:0] out1_pc;
    logic [31:0] out1_inst;
    logic [1:0]  out_pop;

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_two    (in_two),
        .in_pc     (in_pc),
        .in_inst0  (in_inst0),
        .in_inst1  (in_inst1),
        .in_ready  (in_ready),
        .out0_valid(out0_valid),
        .out1_valid(out1_valid),
        .out0_pc   (out0_pc),
        .out0_inst (out0_inst),
        .out1_pc   (out1_pc),
        .out1_inst (out1_inst),
        .out_pop   (out_pop)
    );

    always #5 clk = ~clk;

    logic [63:0] sb[$];
    int          m_count;
    logic        m_byp;
    logic        m_two;
    logic        mon_en;
    int          errors;
    int          checks;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h5A5A_C3C3;
    endfunction

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Monitor: compares the visible head entries against the scoreboard, then retires pops.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                logic e0, e1;
                e0 = (m_count >= 1) || m_byp;
                e1 = (m_count >= 2) || (m_byp && m_two);
                chk("in_ready", {63'd0, in_ready}, {63'd0, (DEPTH - m_count) >= 2});
                chk("out0_valid", {63'd0, out0_valid}, {63'd0, e0});
                chk("out1_valid", {63'd0, out1_valid}, {63'd0, e1});
                if (e0) begin
                    if (sb.size() < 1) begin
                        errors++;
                        $display("FAIL sb_empty0: scoreboard has %0d entries, need 1", sb.size());
                    end else
                        chk("out0", {out0_pc, out0_inst}, sb[0]);
                end
                if (e1) begin
                    if (sb.size() < 2) begin
                        errors++;
                        $display("FAIL sb_empty1: scoreboard has %0d entries, need 2", sb.size());
                    end else
                        chk("out1", {out1_pc, out1_inst}, sb[1]);
                end
                if (!flush) begin
                    for (int i = 0; i < int'(out_pop); i++)
                        if (sb.size() > 0) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic step(input logic v, input logic two, input logic [31:0] pc,
                        input logic [1:0] pop, input logic fl);
        logic acc, byp;
        int   nacc;
        @(negedge clk);
        in_valid = v;
        in_two   = two;
        in_pc    = pc;
        in_inst0 = inst_of(pc);
        in_inst1 = inst_of(pc + 32'd4);
        out_pop  = pop;
        flush    = fl;
        acc  = v && ((DEPTH - m_count) >= 2) && !fl;
        nacc = acc ? (two ? 2 : 1) : 0;
        byp  = 1'b0;
`ifdef FETCH_BUF_BYPASS_EN
        byp  = acc && (m_count == 0);
`endif
        m_byp = byp;
        m_two = two;
        if (!fl && (int'(pop) > m_count + (byp ? nacc : 0))) begin
            errors++;
            $display("FAIL protocol: out_pop=%0d with %0d available", pop, m_count);
        end
        if (acc) begin
            sb.push_back({pc, inst_of(pc)});
            if (two) sb.push_back({pc + 32'd4, inst_of(pc + 32'd4)});
        end
        @(posedge clk);
        if (fl) begin
            m_count = 0;
            sb.delete();
        end else begin
            m_count = m_count + nacc - int'(pop);
        end
    endtask

    task automatic do_reset(input logic busy);
        mon_en   = 1'b0;
        @(negedge clk);
        resetn   = 1'b0;
        in_valid = busy;
        in_two   = busy;
        in_pc    = 32'hBAD0_0F00;
        in_inst0 = 32'hFFFF_FFFF;
        in_inst1 = 32'hFFFF_FFFF;
        out_pop  = busy ? 2'd1 : 2'd0;
        flush    = busy;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn   = 1'b1;
        in_valid = 1'b0;
        in_two   = 1'b0;
        out_pop  = 2'd0;
        flush    = 1'b0;
        m_count  = 0;
        m_byp    = 1'b0;
        m_two    = 1'b0;
        sb.delete();
        mon_en   = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        m_count = 0;
        m_byp = 1'b0;
        m_two = 1'b0;
        mon_en = 1'b0;
        in_pc = '0;
        in_inst0 = '0;
        in_inst1 = '0;
        do_reset(1'b0);

        // Basic pair push, visible next cycle, then drain.
        step(1, 1, 32'h1C00_0000, 2'd0, 0);
        step(0, 0, 32'h0, 2'd0, 0);
        step(0, 0, 32'h0, 2'd2, 0);

        // Fill with pairs until in_ready drops; further pushes ignored.
        for (int i = 0; i < 4; i++)
            step(1, 1, 32'h1C00_1000 + 32'(8 * i), 2'd0, 0);
        step(1, 1, 32'hBAD0_0000, 2'd0, 0);
        step(1, 0, 32'hBAD0_0010, 2'd0, 0);
        step(0, 0, 32'h0, 2'd1, 0);
        // count=7: push rejected even with a same-cycle pop of 2.
        step(1, 1, 32'hBAD0_0100, 2'd2, 0);
        step(0, 0, 32'h0, 2'd0, 0);
        // count=5: flush wins over push and pop.
        step(1, 1, 32'hDEAD_0000, 2'd1, 1);
        step(0, 0, 32'h0, 2'd0, 0);

        // Sustained 2-in/2-out across many pointer wraps.
        step(1, 1, 32'h1C00_0000, 2'd0, 0);
        for (int i = 1; i <= 20; i++)
            step(1, 1, 32'h1C00_0000 + 32'(8 * i), 2'd2, 0);
        step(0, 0, 32'h0, 2'd2, 0);

        // Single-instruction pushes with single pops.
        for (int i = 0; i < 6; i++)
            step(1, 0, 32'h1C10_0000 + 32'(4 * i), (i > 0) ? 2'd1 : 2'd0, 0);
        step(0, 0, 32'h0, 2'd1, 0);

        // Mixed pair pushes and single pops.
        for (int i = 0; i < 4; i++)
            step(1, 1, 32'h1C18_0000 + 32'(8 * i), (i > 0) ? 2'd1 : 2'd0, 0);
        step(0, 0, 32'h0, 2'd2, 0);
        step(0, 0, 32'h0, 2'd2, 0);
        step(0, 0, 32'h0, 2'd1, 0);

`ifdef FETCH_BUF_BYPASS_EN
        // Empty buffer: pair pushed and one consumed in the same cycle.
        step(1, 1, 32'h1C20_0000, 2'd1, 0);
        step(0, 0, 32'h0, 2'd0, 0);
        step(0, 0, 32'h0, 2'd1, 0);
        step(1, 0, 32'h1C20_0100, 2'd1, 0);
        step(0, 0, 32'h0, 2'd0, 0);
`endif

        // Reset overrides a simultaneous push, pop and flush.
        step(1, 1, 32'h1C30_0000, 2'd0, 0);
        do_reset(1'b1);
        step(0, 0, 32'h0, 2'd0, 0);
        step(1, 1, 32'h1C40_0000, 2'd0, 0);
        step(0, 0, 32'h0, 2'd2, 0);
        step(0, 0, 32'h0, 2'd0, 0);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
